decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/control_decoder.sv | 101 ++++++++++
 rtl/decode_stage.sv | 118 +++++++++++
 tb/tb_decode_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation encoding and the
// control bundle carried down the pipeline to EX, MEM and WB.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic       aluSrc;
    logic       memToReg;
    logic [3:0] aluOp;
    logic [2:0] funct3;
  } ctrl_t;

  // instr[30] selects SUB only for register-register ops; it always selects SRA.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                                 input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode-to-control decode, immediate generation and
// source-register usage flags for one RV32I instruction word.
module control_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [31:0] imm_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o
);

  logic [6:0] opc_s;
  logic [2:0] f3_s;
  assign opc_s = instr_i[6:0];
  assign f3_s  = instr_i[14:12];

  always_comb begin
    ctrl_o     = '0;
    imm_o      = 32'd0;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    case (opc_s)
      OPC_OP: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.aluOp    = alu_from_funct(f3_s, instr_i[30], 1'b1);
        ctrl_o.funct3   = f3_s;
        rs1_used_o      = 1'b1;
        rs2_used_o      = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.aluOp    = alu_from_funct(f3_s, instr_i[30], 1'b0);
        ctrl_o.funct3   = f3_s;
        imm_o           = {{20{instr_i[31]}}, instr_i[31:20]};
        rs1_used_o      = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memRead  = 1'b1;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.memToReg = 1'b1;
        ctrl_o.aluOp    = ALU_ADD;
        ctrl_o.funct3   = f3_s;
        imm_o           = {{20{instr_i[31]}}, instr_i[31:20]};
        rs1_used_o      = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.memWrite = 1'b1;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.aluOp    = ALU_ADD;
        ctrl_o.funct3   = f3_s;
        imm_o           = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        rs1_used_o      = 1'b1;
        rs2_used_o      = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.aluOp  = ALU_SUB;
        ctrl_o.funct3 = f3_s;
        imm_o         = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
        rs1_used_o    = 1'b1;
        rs2_used_o    = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.jump     = 1'b1;
        ctrl_o.aluOp    = ALU_ADD;
        imm_o           = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.jump     = 1'b1;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.aluOp    = ALU_ADD;
        ctrl_o.funct3   = f3_s;
        imm_o           = {{20{instr_i[31]}}, instr_i[31:20]};
        rs1_used_o      = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.aluOp    = ALU_PASSB;
        imm_o           = {instr_i[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.aluOp    = ALU_ADD;
        imm_o           = {instr_i[31:12], 12'd0};
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: load-use hazard detection and the ID/EX pipeline
// register, with flush > stall > normal load priority.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ifIdValid,
  input  logic [31:0] ifIdPc,
  input  logic [31:0] ifIdInstr,
  output logic [4:0]  r1Address,
  output logic [4:0]  r2Address,
  input  logic [31:0] r1Data,
  input  logic [31:0] r2Data,
  input  logic        flush,
  output logic        stallFetch,
  output logic        idExValid,
  output logic [31:0] idExPc,
  output logic [31:0] idExRs1Data,
  output logic [31:0] idExRs2Data,
  output logic [31:0] idExImm,
  output logic [4:0]  idExRs1,
  output logic [4:0]  idExRs2,
  output logic [4:0]  idExRd,
  output ctrl_t       idExCtrl
);

  ctrl_t       dec_ctrl_s;
  logic [31:0] dec_imm_s;
  logic        rs1_used_s, rs2_used_s, hazard_s, stall_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;

  logic        valid_d, valid_q;
  ctrl_t       ctrl_d, ctrl_q;
  logic [31:0] pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  logic [4:0]  rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;

  assign rs1_s = ifIdInstr[19:15];
  assign rs2_s = ifIdInstr[24:20];
  assign rd_s  = ifIdInstr[11:7];

  control_decoder u_dec (
    .instr_i    (ifIdInstr),
    .ctrl_o     (dec_ctrl_s),
    .imm_o      (dec_imm_s),
    .rs1_used_o (rs1_used_s),
    .rs2_used_o (rs2_used_s)
  );

  // Reset gating keeps the stall low while the pipeline is being cleared.
  assign hazard_s = valid_q && ctrl_q.memRead && (rd_q != 5'd0) &&
                    ((rs1_used_s && (rs1_s == rd_q)) || (rs2_used_s && (rs2_s == rd_q)));
  assign stall_s  = ifIdValid && hazard_s && !flush && !reset;

  // Next ID/EX contents; bubbles clear valid/ctrl and hold the data fields.
  always_comb begin
    valid_d    = 1'b0;
    ctrl_d     = '0;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    if (flush || stall_s || !ifIdValid) begin
      valid_d = 1'b0;
    end else begin
      valid_d    = 1'b1;
      ctrl_d     = dec_ctrl_s;
      pc_d       = ifIdPc;
      rs1_data_d = r1Data;
      rs2_data_d = r2Data;
      imm_d      = dec_imm_s;
      rs1_d      = rs1_s;
      rs2_d      = rs2_s;
      rd_d       = rd_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= 32'd0;
      rs1_data_q <= 32'd0;
      rs2_data_q <= 32'd0;
      imm_q      <= 32'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  assign r1Address   = rs1_s;
  assign r2Address   = rs2_s;
  assign stallFetch  = stall_s;
  assign idExValid   = valid_q;
  assign idExCtrl    = ctrl_q;
  assign idExPc      = pc_q;
  assign idExRs1Data = rs1_data_q;
  assign idExRs2Data = rs2_data_q;
  assign idExImm     = imm_q;
  assign idExRs1     = rs1_q;
  assign idExRs2     = rs2_q;
  assign idExRd      = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with hand-computed expectations.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, ifIdValid, flush, stallFetch, idExValid;
  logic [31:0] ifIdPc, ifIdInstr, r1Data, r2Data;
  logic [31:0] idExPc, idExRs1Data, idExRs2Data, idExImm;
  logic [4:0]  r1Address, r2Address, idExRs1, idExRs2, idExRd;
  ctrl_t       idExCtrl, exp_ctrl;
  int          checks = 0;
  int          failures = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] I_LW   = 32'h0000A103; // lw x2,0(x1)
  localparam logic [31:0] I_LW0  = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] I_ADD  = 32'h004101B3; // add x3,x2,x4
  localparam logic [31:0] I_ADDZ = 32'h004001B3; // add x3,x0,x4
  localparam logic [31:0] I_LUI  = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] I_SW   = 32'hFE20AE23; // sw x2,-4(x1)
  localparam logic [31:0] I_JALP = 32'h0010006F; // jal x0,+2048
  localparam logic [31:0] I_JALN = 32'hFFFFF0EF; // jal x1,-2
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  decode_stage dut (
    .clk(clk), .reset(reset), .ifIdValid(ifIdValid), .ifIdPc(ifIdPc), .ifIdInstr(ifIdInstr),
    .r1Address(r1Address), .r2Address(r2Address), .r1Data(r1Data), .r2Data(r2Data),
    .flush(flush), .stallFetch(stallFetch), .idExValid(idExValid), .idExPc(idExPc),
    .idExRs1Data(idExRs1Data), .idExRs2Data(idExRs2Data), .idExImm(idExImm),
    .idExRs1(idExRs1), .idExRs2(idExRs2), .idExRd(idExRd), .idExCtrl(idExCtrl)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] d1, input logic [31:0] d2, input logic fl);
    ifIdValid = v; ifIdPc = pc; ifIdInstr = ins; r1Data = d1; r2Data = d2; flush = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h40, I_LW, 32'h1, 32'h2, 1'b0);
    step(); step();
    checks++;
    if ({idExValid, idExCtrl, idExPc, idExRs1Data, idExRs2Data, idExImm, idExRs1, idExRs2, idExRd} !== '0) begin
      failures++; $display("FAIL reset_regs valid=%b ctrl=%h pc=%h imm=%h rd=%0d exp all zero",
                           idExValid, idExCtrl, idExPc, idExImm, idExRd);
    end
    checks++;
    if (stallFetch !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", stallFetch);
    end
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h100, I_ADDI, 32'h0, 32'h0, 1'b0);
    checks++;
    if (r1Address !== 5'd0 || r2Address !== 5'd5) begin
      failures++; $display("FAIL addi_raddr got=%0d/%0d exp=0/5", r1Address, r2Address);
    end
    step();
    exp_ctrl = '0; exp_ctrl.regWrite = 1'b1; exp_ctrl.aluSrc = 1'b1; exp_ctrl.aluOp = ALU_ADD;
    checks++;
    if (idExValid !== 1'b1 || idExImm !== 32'd5 || idExRd !== 5'd1 || idExPc !== 32'h100) begin
      failures++; $display("FAIL addi_fields valid=%b imm=%h rd=%0d pc=%h exp 1/5/1/100",
                           idExValid, idExImm, idExRd, idExPc);
    end
    checks++;
    if (idExCtrl !== exp_ctrl) begin
      failures++; $display("FAIL addi_ctrl got=%h exp=%h", idExCtrl, exp_ctrl);
    end
  endtask

  task automatic test_imm_formats();
    drive(1'b1, 32'h104, I_BEQ, 32'h0, 32'h0, 1'b0);
    step();
    checks++;
    if (idExImm !== 32'hFFFFFFFC || idExCtrl.branch !== 1'b1 || idExCtrl.regWrite !== 1'b0) begin
      failures++; $display("FAIL beq imm=%h br=%b rw=%b exp fffffffc/1/0",
                           idExImm, idExCtrl.branch, idExCtrl.regWrite);
    end
    drive(1'b1, 32'h108, I_SW, 32'h0, 32'h0, 1'b0);
    step();
    checks++;
    if (idExImm !== 32'hFFFFFFFC || idExCtrl.memWrite !== 1'b1 || idExRs2 !== 5'd2) begin
      failures++; $display("FAIL sw imm=%h mw=%b rs2=%0d exp fffffffc/1/2",
                           idExImm, idExCtrl.memWrite, idExRs2);
    end
    drive(1'b1, 32'h10C, I_LUI, 32'h0, 32'h0, 1'b0);
    step();
    checks++;
    if (idExImm !== 32'h12345000 || idExRd !== 5'd5 || idExCtrl.regWrite !== 1'b1) begin
      failures++; $display("FAIL lui imm=%h rd=%0d exp 12345000/5", idExImm, idExRd);
    end
    drive(1'b1, 32'h110, I_JALP, 32'h0, 32'h0, 1'b0);
    step();
    checks++;
    if (idExImm !== 32'h00000800 || idExCtrl.jump !== 1'b1) begin
      failures++; $display("FAIL jal_pos imm=%h jump=%b exp 00000800/1", idExImm, idExCtrl.jump);
    end
    drive(1'b1, 32'h114, I_JALN, 32'h0, 32'h0, 1'b0);
    step();
    checks++;
    if (idExImm !== 32'hFFFFFFFE || idExRd !== 5'd1 || idExCtrl.regWrite !== 1'b1) begin
      failures++; $display("FAIL jal_neg imm=%h rd=%0d exp fffffffe/1", idExImm, idExRd);
    end
    drive(1'b1, 32'h118, I_BAD, 32'h0, 32'h0, 1'b0);
    step();
    checks++;
    if (idExCtrl !== '0 || idExValid !== 1'b1) begin
      failures++; $display("FAIL undef_ctrl ctrl=%h valid=%b exp 0/1", idExCtrl, idExValid);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h200, I_LW, 32'h100, 32'h0, 1'b0);
    step();
    checks++;
    if (idExCtrl.memRead !== 1'b1 || idExRd !== 5'd2) begin
      failures++; $display("FAIL lw_issue mr=%b rd=%0d exp 1/2", idExCtrl.memRead, idExRd);
    end
    drive(1'b1, 32'h204, I_ADD, 32'hAAAA, 32'h4444, 1'b0);
    checks++;
    if (stallFetch !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b exp=1", stallFetch);
    end
    step();
    checks++;
    if (idExValid !== 1'b0 || idExCtrl !== '0 || idExPc !== 32'h200 || idExRd !== 5'd2) begin
      failures++; $display("FAIL lu_bubble valid=%b ctrl=%h pc=%h rd=%0d exp 0/0/200/2",
                           idExValid, idExCtrl, idExPc, idExRd);
    end
    drive(1'b1, 32'h204, I_ADD, 32'h5555, 32'h4444, 1'b0);
    checks++;
    if (stallFetch !== 1'b0) begin
      failures++; $display("FAIL lu_stall_once got=%b exp=0", stallFetch);
    end
    step();
    checks++;
    if (idExValid !== 1'b1 || idExRs1Data !== 32'h5555 || idExRs2Data !== 32'h4444 ||
        idExRd !== 5'd3 || idExRs1 !== 5'd2 || idExRs2 !== 5'd4 || idExPc !== 32'h204) begin
      failures++; $display("FAIL lu_reissue valid=%b d1=%h d2=%h rd=%0d rs=%0d/%0d pc=%h exp 1/5555/4444/3/2/4/204",
                           idExValid, idExRs1Data, idExRs2Data, idExRd, idExRs1, idExRs2, idExPc);
    end
  endtask

  task automatic test_no_stall_cases();
    drive(1'b1, 32'h300, I_LW, 32'h0, 32'h0, 1'b0);
    step();
    drive(1'b1, 32'h304, I_ADD, 32'h0, 32'h0, 1'b1);
    checks++;
    if (stallFetch !== 1'b0) begin
      failures++; $display("FAIL flush_stall got=%b exp=0", stallFetch);
    end
    step();
    checks++;
    if (idExValid !== 1'b0 || idExCtrl !== '0) begin
      failures++; $display("FAIL flush_bubble valid=%b ctrl=%h exp 0/0", idExValid, idExCtrl);
    end
    drive(1'b1, 32'h308, I_LW, 32'h0, 32'h0, 1'b0);
    step();
    drive(1'b1, 32'h30C, I_LUI, 32'h0, 32'h0, 1'b0);
    checks++;
    if (stallFetch !== 1'b0) begin
      failures++; $display("FAIL lui_nostall got=%b exp=0", stallFetch);
    end
    drive(1'b0, 32'h30C, I_ADD, 32'h0, 32'h0, 1'b0);
    checks++;
    if (stallFetch !== 1'b0) begin
      failures++; $display("FAIL invalid_nostall got=%b exp=0", stallFetch);
    end
    step();
    checks++;
    if (idExValid !== 1'b0) begin
      failures++; $display("FAIL invalid_bubble valid=%b exp=0", idExValid);
    end
    drive(1'b1, 32'h310, I_LW0, 32'h0, 32'h0, 1'b0);
    step();
    drive(1'b1, 32'h314, I_ADDZ, 32'h0, 32'h0, 1'b0);
    checks++;
    if (stallFetch !== 1'b0) begin
      failures++; $display("FAIL rd0_nostall got=%b exp=0", stallFetch);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h400, I_LW, 32'h0, 32'h0, 1'b0);
    step();
    drive(1'b1, 32'h404, I_ADD, 32'h77, 32'h88, 1'b0);
    checks++;
    if (stallFetch !== 1'b1) begin
      failures++; $display("FAIL rst_pre_stall got=%b exp=1", stallFetch);
    end
    reset = 1'b1;
    #1;
    step();
    checks++;
    if ({idExValid, idExCtrl, idExPc, idExRs1Data, idExRs2Data, idExImm, idExRs1, idExRs2, idExRd, stallFetch} !== '0) begin
      failures++; $display("FAIL rst_mid_stall valid=%b ctrl=%h pc=%h rd=%0d stall=%b exp all zero",
                           idExValid, idExCtrl, idExPc, idExRd, stallFetch);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (stallFetch !== 1'b0) begin
      failures++; $display("FAIL rst_after_stall got=%b exp=0", stallFetch);
    end
    step();
    checks++;
    if (idExValid !== 1'b1 || idExRd !== 5'd3 || idExRs1Data !== 32'h77 || idExPc !== 32'h404) begin
      failures++; $display("FAIL rst_resume valid=%b rd=%0d d1=%h pc=%h exp 1/3/77/404",
                           idExValid, idExRd, idExRs1Data, idExPc);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_addi();
    test_imm_formats();
    test_load_use();
    test_no_stall_cases();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
